// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel clock-enable generator qualified by PLL lock.
// The 2-flop synchroniser feeds a lock qualification FSM. Each channel has
// a shadow and an active configuration set. Each channel produces a registered
// single-cycle strobe while the FSM is in RUN and lock is still present.
module clk_en_gen #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 16,
    parameter int LOCK_CNT = 1024
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] ce,
    output logic              ready,
    output logic [7:0]        lock_loss_cnt
);

    localparam int LCW = $clog2(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_QUALIFY   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------
    logic r_lock_meta;
    logic r_lock_s;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // ------------------------------------------------------------------
    // Lock qualification FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_next;
    logic [LCW-1:0] r_stable_cnt;
    logic [LCW-1:0] w_stable_next;
    logic [7:0]     r_loss_cnt;
    logic [7:0]     w_loss_next;
    logic           w_run;

    // State, stability counter and lock-loss counter registers.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_stable_cnt <= '0;
            r_loss_cnt   <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_stable_cnt <= w_stable_next;
            r_loss_cnt   <= w_loss_next;
        end
    end

    // Next-state logic: lock must stay high for LOCK_CNT counted cycles in
    // QUALIFY; any dropout restarts qualification from WAIT_LOCK.
    always_comb begin
        w_state_next  = r_state;
        w_stable_next = r_stable_cnt;
        w_loss_next   = r_loss_cnt;
        case (r_state)
            ST_IDLE: begin
                w_state_next  = ST_WAIT_LOCK;
                w_stable_next = '0;
            end
            ST_WAIT_LOCK: begin
                w_stable_next = '0;
                if (r_lock_s) begin
                    w_state_next = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (!r_lock_s) begin
                    w_state_next  = ST_WAIT_LOCK;
                    w_stable_next = '0;
                end else if (r_stable_cnt == LCW'(LOCK_CNT - 1)) begin
                    w_state_next  = ST_RUN;
                    w_stable_next = '0;
                end else begin
                    w_stable_next = r_stable_cnt + LCW'(1);
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                    if (r_loss_cnt != 8'hFF) begin
                        w_loss_next = r_loss_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_stable_next = '0;
            end
        endcase
    end

    assign w_run         = (r_state == ST_RUN);
    assign ready         = w_run;
    assign lock_loss_cnt = r_loss_cnt;

    // ------------------------------------------------------------------
    // Shared write decode: phase is clamped against the divide value that
    // arrives with it, so the shadow never holds an unreachable phase.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] w_phase_clamped;
    assign w_phase_clamped = (cfg_phase > cfg_div) ? cfg_div : cfg_phase;

    // ------------------------------------------------------------------
    // Per-channel divider
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] r_sh_div;
            logic [DIV_W-1:0] r_sh_phase;
            logic             r_sh_en;
            logic [DIV_W-1:0] r_div;
            logic [DIV_W-1:0] r_phase;
            logic             r_en;
            logic [DIV_W-1:0] r_cnt;
            logic             r_ce;

            logic             w_hit;
            logic             w_wrap;
            logic             w_apply;
            logic [DIV_W-1:0] w_src_div;
            logic [DIV_W-1:0] w_src_phase;
            logic             w_src_en;
            logic [DIV_W-1:0] w_cnt_next;
            logic             w_ce_next;

            // Channel numbers >= NUM_CH have no matching instance, so such
            // writes fall through without touching any state.
            assign w_hit = cfg_wr && (cfg_ch == 3'(gi));

            // A write landing in the same cycle as a copy bypasses the shadow,
            // so the copy always uses the newest value.
            assign w_src_div   = w_hit ? cfg_div         : r_sh_div;
            assign w_src_phase = w_hit ? w_phase_clamped : r_sh_phase;
            assign w_src_en    = w_hit ? cfg_en          : r_sh_en;

            // Outside RUN the active set follows the shadow continuously; in
            // RUN it only changes at a period boundary or on a realign.
            assign w_wrap  = (r_cnt == r_div);
            assign w_apply = !w_run || sync || w_wrap;

            // Counter: held at zero outside RUN, restarted by sync or wrap.
            always_comb begin
                w_cnt_next = r_cnt + DIV_W'(1);
                if (!w_run || sync || w_wrap) begin
                    w_cnt_next = '0;
                end
            end

            assign w_ce_next = w_run && r_lock_s && r_en && (r_cnt == r_phase);

            // Shadow set: captures host writes addressed to this channel.
            always_ff @(posedge refclk) begin
                if (!rst_n) begin
                    r_sh_div   <= '0;
                    r_sh_phase <= '0;
                    r_sh_en    <= 1'b0;
                end else if (w_hit) begin
                    r_sh_div   <= cfg_div;
                    r_sh_phase <= w_phase_clamped;
                    r_sh_en    <= cfg_en;
                end
            end

            // Active set, period counter and registered strobe.
            always_ff @(posedge refclk) begin
                if (!rst_n) begin
                    r_div   <= '0;
                    r_phase <= '0;
                    r_en    <= 1'b0;
                    r_cnt   <= '0;
                    r_ce    <= 1'b0;
                end else begin
                    if (w_apply) begin
                        r_div   <= w_src_div;
                        r_phase <= w_src_phase;
                        r_en    <= w_src_en;
                    end
                    r_cnt <= w_cnt_next;
                    r_ce  <= w_ce_next;
                end
            end

            assign ce[gi] = r_ce;
        end
    endgenerate

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen.
// Stimulus pushes the predicted outputs into a scoreboard queue. A monitor
// compares those predictions against the DUT at every falling edge. The
// reference model describes lock by consecutive-high streak length. It
// describes each channel by the cycle its current period began.
module tb_clk_en_gen;

    localparam int NUM_CH   = 4;
    localparam int DIV_W    = 16;
    localparam int LOCK_CNT = 16;

    logic              refclk = 1'b0;
    logic              rst_n;
    logic              pll_locked;
    logic              cfg_wr;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_en;
    logic              sync;
    logic [NUM_CH-1:0] ce;
    logic              ready;
    logic [7:0]        lock_loss_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] ce;
        logic              rdy;
        logic [7:0]        loss;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state (values valid during the current cycle).
    bit m_p1, m_ls, m_ready;
    int m_streak, m_loss;
    int m_div[NUM_CH], m_ph[NUM_CH], m_anchor[NUM_CH];
    bit m_en[NUM_CH];
    int s_div[NUM_CH], s_ph[NUM_CH];
    bit s_en[NUM_CH];

    clk_en_gen #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .cfg_wr        (cfg_wr),
        .cfg_ch        (cfg_ch),
        .cfg_div       (cfg_div),
        .cfg_phase     (cfg_phase),
        .cfg_en        (cfg_en),
        .sync          (sync),
        .ce            (ce),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial forever #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Predict the outputs after the next rising edge from the inputs
    // currently applied, then advance the model by one cycle.
    task automatic predict();
        exp_t e;
        int   k;
        bit   rn;
        k = cyc;
        e.cyc = k + 1;
        if (rst_n !== 1'b1) begin
            m_p1 = 0; m_ls = 0; m_ready = 0; m_streak = 0; m_loss = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 0; m_ph[i] = 0; m_en[i] = 0; m_anchor[i] = 0;
                s_div[i] = 0; s_ph[i] = 0; s_en[i] = 0;
            end
            e.ce = '0; e.rdy = 1'b0; e.loss = 8'd0;
        end else begin
            // RUN next cycle iff lock_s has been high for LOCK_CNT+1 straight cycles.
            rn = (m_streak >= LOCK_CNT + 1);
            for (int i = 0; i < NUM_CH; i++) begin
                e.ce[i] = m_ready && m_ls && m_en[i] && ((k - m_anchor[i]) == m_ph[i]);
            end
            if (m_ready && !rn && m_loss < 255) m_loss++;
            if (cfg_wr && int'(cfg_ch) < NUM_CH) begin
                s_div[cfg_ch] = int'(cfg_div);
                s_ph[cfg_ch]  = (cfg_phase > cfg_div) ? int'(cfg_div) : int'(cfg_phase);
                s_en[cfg_ch]  = cfg_en;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!m_ready || sync || ((k - m_anchor[i]) == m_div[i])) begin
                    m_div[i] = s_div[i];
                    m_ph[i]  = s_ph[i];
                    m_en[i]  = s_en[i];
                    m_anchor[i] = k + 1;
                end
            end
            m_ready = rn;
            m_ls = m_p1;
            if (m_ls) begin
                if (m_streak < 1000000) m_streak++;
            end else begin
                m_streak = 0;
            end
            m_p1 = pll_locked;
            e.rdy  = rn;
            e.loss = 8'(m_loss);
        end
        sb_q.push_back(e);
    endtask

    // Monitor: pop the prediction for the edge just taken and compare.
    always @(negedge refclk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            check("sb_cycle", e.cyc, cyc);
            check("ce", 32'(ce), 32'(e.ce));
            check("ready", 32'(ready), 32'(e.rdy));
            check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e.loss));
        end
    end

    task automatic step();
        predict();
        @(posedge refclk);
        #1;
        cfg_wr = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write_cfg(input int ch, input int d, input int p, input bit en);
        cfg_wr    = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = DIV_W'(d);
        cfg_phase = DIV_W'(p);
        cfg_en    = en;
        $display("txn cyc=%0d write ch=%0d div=%0d phase=%0d en=%0d", cyc, ch, d, p, en);
        step();
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        $display("txn cyc=%0d sync", cyc);
        step();
    endtask

    task automatic drop_lock(input int n);
        $display("txn cyc=%0d lock drop for %0d cycles", cyc, n);
        pll_locked = 1'b0;
        run(n);
        pll_locked = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel;
        int t;
        int r;
        rst_n = 1'b0; pll_locked = 1'b1; cfg_wr = 1'b0; cfg_ch = 3'd0;
        cfg_div = '0; cfg_phase = '0; cfg_en = 1'b0; sync = 1'b0;

        // Reset with lock already high, then measure the qualification time.
        $display("txn cyc=%0d reset", cyc);
        run(3);
        rst_n = 1'b1;
        rel = cyc;
        write_cfg(0, 3, 1, 1'b1);
        write_cfg(1, 0, 0, 1'b1);
        write_cfg(2, 5, 2, 1'b1);
        write_cfg(3, 4, 9, 1'b0);
        t = -1;
        for (int i = 0; i < 100 && t < 0; i++) begin
            step();
            if (ready === 1'b1) t = cyc - rel;
        end
        check("ready_rise_delay", t, LOCK_CNT + 3);
        run(40);

        // Change ch0 ratio mid-period.
        run(2);
        write_cfg(0, 7, 1, 1'b1);
        run(40);

        // One-cycle lock dropout in RUN.
        drop_lock(1);
        run(30);
        check("loss_after_drop", 32'(lock_loss_cnt), 32'd1);
        check("ready_requalified", 32'(ready), 32'd1);

        // Dropout during QUALIFY must restart the count and not bump the counter twice.
        drop_lock(1);
        run(10);
        drop_lock(1);
        run(30);
        check("loss_after_qualify_drop", 32'(lock_loss_cnt), 32'd2);

        // Realignment with common divide and staggered phases.
        write_cfg(0, 5, 0, 1'b1);
        write_cfg(1, 5, 2, 1'b1);
        write_cfg(2, 5, 4, 1'b1);
        run(20);
        for (int i = 0; i < 8; i++) begin
            run($urandom_range(3, 11));
            pulse_sync();
        end
        pulse_sync();
        run(5);
        pulse_sync();
        run(20);

        // Writes to channels that do not exist.
        write_cfg(5, 1, 0, 1'b1);
        write_cfg(7, 0, 0, 1'b0);
        run(20);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                write_cfg($urandom_range(0, 7), $urandom_range(0, 9),
                          $urandom_range(0, 12), 1'($urandom_range(0, 1)));
            end else if (r < 14) begin
                pulse_sync();
            end else if (r == 14) begin
                drop_lock($urandom_range(1, 3));
            end else begin
                step();
            end
        end

        // Reset in the middle of RUN.
        pll_locked = 1'b1;
        run(30);
        $display("txn cyc=%0d reset", cyc);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        write_cfg(0, 2, 1, 1'b1);
        write_cfg(1, 1, 1, 1'b1);
        run(40);

        // Drive the lock-loss counter into saturation.
        for (int i = 0; i < 300; i++) begin
            drop_lock(1);
            run(24);
        end
        check("loss_saturated", 32'(lock_loss_cnt), 32'd255);

        run(3);
        repeat (2) @(negedge refclk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Multi-channel clock-enable generator with PLL lock qualification, sitting directly after the fabric PLL in the clock subsystem. Runs on the PLL output clock and produces NUM_CH independently programmable single-cycle enable strobes (divide ratio, phase offset, per-channel enable). The strobes are emitted only after the PLL lock has been stable for a programmable window. Lock loss is detected, counted and forces every strobe low until lock is re-qualified.

## Interface
Parameters:
- NUM_CH, 4: number of enable channels (1..8).
- DIV_W, 16: width of divide and phase fields.
- LOCK_CNT, 1024: consecutive synchronised-lock cycles required before RUN (>=2).

Ports:
- refclk  in  1  sole clock (PLL output); all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to refclk.
- cfg_wr  in  1  configuration write strobe, one cycle.
- cfg_ch  in  3  target channel; writes with cfg_ch >= NUM_CH are ignored.
- cfg_div  in  DIV_W  divide value D; strobe period = D+1 cycles.
- cfg_phase  in  DIV_W  phase P; values above D are clamped to D.
- cfg_en  in  1  channel enable.
- sync  in  1  one-cycle request to realign all channel counters.
- ce  out  NUM_CH  enable strobes, one bit per channel.
- ready  out  1  high while in RUN.
- lock_loss_cnt  out  8  saturating count of RUN->WAIT_LOCK transitions.

## Operation
- pll_locked passes through a 2-flop synchroniser, giving lock_s (2-cycle latency).
- FSM states and transitions:
  - IDLE (reset state) -> WAIT_LOCK unconditionally.
  - WAIT_LOCK: stable counter held at 0; -> QUALIFY when lock_s=1.
  - QUALIFY: counter increments each lock_s=1 cycle; lock_s=0 -> WAIT_LOCK, counter cleared; counter reaching LOCK_CNT-1 while lock_s=1 -> RUN.
  - RUN: lock_s=0 -> WAIT_LOCK, lock_loss_cnt increments (saturates at 255).
- Per channel there is an active set {D, P, en}, a shadow set, and counter cnt (DIV_W bits).
- cnt is cleared on RUN entry and increments each RUN cycle, wrapping D -> 0. D=0 gives a strobe every cycle.
- ce[i] is registered: high when state==RUN, lock_s=1, en=1 and cnt==P on the previous cycle.
- cfg_wr loads the shadow set. The shadow is copied to the active set:
  - immediately (next cycle) when state != RUN;
  - in RUN, on the cycle cnt wraps (cnt==D), so a new ratio never produces a runt or double strobe;
  - on sync.
- sync in RUN clears every cnt to 0 and applies all shadows in the same cycle. sync outside RUN is ignored.
- Simultaneous events:
  - sync and a wrap: sync wins (cnt=0, shadow applied once).
  - cfg_wr and a wrap on the same channel: the copy uses the value written that cycle.
  - cfg_wr and sync: the new value takes effect.
- Reset values (rst_n low, sampled at a clock edge): state IDLE, ce=0, ready=0, lock_loss_cnt=0, all cnt=0, active and shadow D=0, P=0, en=0. Reset mid-RUN drops every output to its reset value on the next edge.

## Timing
- pll_locked rise to ready rise: 2 (sync) + 1 (WAIT_LOCK->QUALIFY) + LOCK_CNT cycles, with no dropout.
- ready rises at cycle T, when cnt=0. First ce[i] at T+P+1, then every D+1 cycles.
- Lock loss: lock_s falls at cycle t. ce and ready are low at t+1, and lock_loss_cnt is updated at t+1.
- sync asserted at cycle s: cnt=0 at s+1, and the next strobe of each channel is at s+P+2.
- Config write in RUN takes effect after the current period completes. Worst-case delay is old D+1 cycles.

## Test plan
- Reset, LOCK_CNT=16, pll_locked held high from cycle 0 -> ready rises exactly 19 cycles after the first post-reset cycle; ce=0 until then.
- ch0 D=3 P=1 en=1, ch1 D=0 en=1 -> ch0 strobes every 4 cycles starting at T+2; ch1 strobes every cycle starting at T+1.
- ch0 running with D=3, write D=7 mid-period -> the remaining old period completes (4 cycles), then spacing becomes 8. No gap shorter than 4.
- pll_locked pulled low for 1 cycle in RUN -> ready and ce low 3 cycles later, lock_loss_cnt=1, re-qualification takes the full LOCK_CNT. A dropout during QUALIFY restarts the count.
- Channels with D=5 P=0/2/4, sync pulsed mid-run -> all counters realign, strobes at s+2, s+4, s+6. sync coinciding with a wrap still realigns once.
- Write cfg_ch=5 with NUM_CH=4 -> no state change. Force 300 lock losses -> lock_loss_cnt saturates at 255.
